// File: rtl/layer_seq_if.sv
// Layer sequencer bus: table writes, sequence control and layer outputs.
// LAYER_SEQ_LOOP_EN adds the iter input and the pass_cnt output.
interface layer_seq_if #(
  parameter int DEPTH = 8
) ();
  localparam int AW = $clog2(DEPTH);

  logic          tw_en;
  logic [AW+1:0] tw_addr;
  logic [31:0]   tw_data;
  logic [AW:0]   n_layers;
  logic          start;
  logic          abort;
  logic          done_in;
  logic [127:0]  cfg;
  logic          run;
  logic          wwrite;
  logic          bwrite;
  logic          busy;
  logic [AW-1:0] cur_idx;
  logic          seq_done;
  logic          aborted;
  logic          wr_err;
`ifdef LAYER_SEQ_LOOP_EN
  logic [7:0]    iter;
  logic [7:0]    pass_cnt;
`endif

  modport master (
`ifdef LAYER_SEQ_LOOP_EN
    output iter,
    input  pass_cnt,
`endif
    output tw_en, tw_addr, tw_data,
    output n_layers, start, abort, done_in,
    input  cfg, run, wwrite, bwrite, busy,
    input  cur_idx, seq_done, aborted, wr_err
  );

  modport slave (
`ifdef LAYER_SEQ_LOOP_EN
    input  iter,
    output pass_cnt,
`endif
    input  tw_en, tw_addr, tw_data,
    input  n_layers, start, abort, done_in,
    output cfg, run, wwrite, bwrite, busy,
    output cur_idx, seq_done, aborted, wr_err
  );
endinterface

// File: rtl/layer_seq.sv
// Layer sequencer: steps a descriptor table, strobing one mode per layer.
// LAYER_SEQ_LOOP_EN repeats the whole table iter+1 times.
module layer_seq #(
  parameter int DEPTH     = 8,
  parameter int SETUP_CYC = 2,
  parameter int GAP_CYC   = 2
) (
  input logic       clk,
  input logic       rst,
  layer_seq_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    IDLE, LOAD, SETUP, ACTIVE, GAP
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [AW:0]        nl_q, nl_d;
  logic               busy_q, busy_d;
  logic [2:0]         strb_q, strb_d;
  logic [127:0]       cfg_q, cfg_d;
  logic [3:0][31:0]   shd_q, shd_d;
  logic               done_q, done_d;
  logic               abt_q, abt_d;
  logic               werr_q, werr_d;
`ifdef LAYER_SEQ_LOOP_EN
  logic [7:0]         iter_q, iter_d;
  logic [7:0]         pass_q, pass_d;
`endif

  logic [31:0]        mem [4*DEPTH];
  logic [31:0]        rd_word;
  logic [AW:0]        nxt_idx;
  logic               last;

  // table is deliberately not reset
  always_ff @(posedge clk) begin
    if (bus.tw_en && !busy_q)
      mem[bus.tw_addr] <= bus.tw_data;
  end

  assign rd_word = mem[{idx_q, cnt_q[1:0]}];
  assign nxt_idx = {1'b0, idx_q} + (AW+1)'(1);
  assign last    = (idx_q == AW'(DEPTH-1))
                || (nxt_idx >= nl_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    nl_d    = nl_q;
    busy_d  = busy_q;
    strb_d  = strb_q;
    cfg_d   = cfg_q;
    shd_d   = shd_q;
    done_d  = 1'b0;
    abt_d   = 1'b0;
    werr_d  = bus.tw_en & busy_q;
`ifdef LAYER_SEQ_LOOP_EN
    iter_d  = iter_q;
    pass_d  = pass_q;
`endif
    if (bus.abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      busy_d  = 1'b0;
      strb_d  = '0;
      abt_d   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.n_layers == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = LOAD;
              busy_d  = 1'b1;
              idx_d   = '0;
              cnt_d   = '0;
              nl_d    = bus.n_layers;
`ifdef LAYER_SEQ_LOOP_EN
              iter_d  = bus.iter;
              pass_d  = '0;
`endif
            end
          end
        end
        LOAD: begin
          if (cnt_q == 4'd4) begin
            cfg_d = shd_q;
            cnt_d = '0;
            if (shd_q[0][29:28] == 2'd3) begin
              state_d = IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = SETUP;
            end
          end else begin
            shd_d[cnt_q[1:0]] = rd_word;
            cnt_d = cnt_q + 4'd1;
          end
        end
        SETUP: begin
          if (cnt_q == 4'(SETUP_CYC-1)) begin
            state_d = ACTIVE;
            cnt_d   = '0;
            strb_d  = 3'b001 << cfg_q[29:28];
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        ACTIVE: begin
          if (bus.done_in) begin
            state_d = GAP;
            strb_d  = '0;
          end
        end
        GAP: begin
          if (cnt_q == 4'(GAP_CYC-1)) begin
            cnt_d = '0;
            if (!last) begin
              idx_d   = idx_q + AW'(1);
              state_d = LOAD;
`ifdef LAYER_SEQ_LOOP_EN
            end else if (pass_q != iter_q) begin
              pass_d  = pass_q + 8'd1;
              idx_d   = '0;
              state_d = LOAD;
`endif
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      nl_q    <= '0;
      busy_q  <= 1'b0;
      strb_q  <= '0;
      cfg_q   <= '0;
      shd_q   <= '0;
      done_q  <= 1'b0;
      abt_q   <= 1'b0;
      werr_q  <= 1'b0;
`ifdef LAYER_SEQ_LOOP_EN
      iter_q  <= '0;
      pass_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      nl_q    <= nl_d;
      busy_q  <= busy_d;
      strb_q  <= strb_d;
      cfg_q   <= cfg_d;
      shd_q   <= shd_d;
      done_q  <= done_d;
      abt_q   <= abt_d;
      werr_q  <= werr_d;
`ifdef LAYER_SEQ_LOOP_EN
      iter_q  <= iter_d;
      pass_q  <= pass_d;
`endif
    end
  end

  assign bus.cfg      = cfg_q;
  assign bus.run      = strb_q[0];
  assign bus.wwrite   = strb_q[1];
  assign bus.bwrite   = strb_q[2];
  assign bus.busy     = busy_q;
  assign bus.cur_idx  = idx_q;
  assign bus.seq_done = done_q;
  assign bus.aborted  = abt_q;
  assign bus.wr_err   = werr_q;
`ifdef LAYER_SEQ_LOOP_EN
  assign bus.pass_cnt = pass_q;
`endif
endmodule

// File: doc/layer_seq.md
Name: layer_seq

Overview:
- Layer sequencer for the tiny_dnn accelerator.
- Holds a small descriptor table of per-layer configurations, written by software.
- On start it steps through the table. For each layer it presents the configuration (backprop, enbias, ss/ds, id/od/dd, is/os, fs/ks/kh/kw, ih/iw/oh/ow), raises the layer's mode strobe (run, wwrite or bwrite), waits for completion, then advances.
- Sits between the register block and batch_ctrl/tiny_dnn_ex_ctl, replacing per-layer software register pokes.

Parameters:
- DEPTH, 8, number of descriptors (power of 2); each descriptor is 4 x 32-bit words.
- SETUP_CYC, 2, cycles the config is held stable before the mode strobe rises (range 1..15).
- GAP_CYC, 2, cycles all mode strobes are held low between layers (range 1..15); this gives rst(~run) time to clear the downstream controllers.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- tw_en  in  1  table write strobe.
- tw_addr  in  log2(DEPTH)+2  table word address; {desc index, word[1:0]}.
- tw_data  in  32  table write data.
- n_layers  in  log2(DEPTH)+1  number of descriptors to execute (0..DEPTH).
- start  in  1  one-cycle start pulse.
- abort  in  1  one-cycle abort pulse.
- done_in  in  1  layer-complete pulse from the batch controller.
- cfg  out  128  current descriptor {w3,w2,w1,w0}.
- run  out  1  mode strobe, run.
- wwrite  out  1  mode strobe, weight write.
- bwrite  out  1  mode strobe, bias write.
- busy  out  1  sequence in progress.
- cur_idx  out  log2(DEPTH)  index of the current descriptor.
- seq_done  out  1  one-cycle pulse at normal completion.
- aborted  out  1  one-cycle pulse on abort.
- wr_err  out  1  one-cycle pulse when a table write is attempted while busy.

Behaviour:
- Descriptor layout:
  - w0: [31] backprop, [30] enbias, [29:28] mode (0 run, 1 wwrite, 2 bwrite, 3 END), [23:12] ss, [11:0] ds.
  - w1: [31:28] id, [27:24] od, [23:20] dd, [19:10] is, [9:0] os.
  - w2: [29:20] fs, [19:10] ks, [9:5] kh, [4:0] kw.
  - w3: [19:15] ih, [14:10] iw, [9:5] oh, [4:0] ow.
  - Unlisted bits are stored but have no meaning.
- Table storage:
  - Register array of 4*DEPTH words, one read per cycle.
  - A write when not busy takes effect at the next edge.
  - A write while busy is dropped and pulses wr_err.
- Reset: all outputs 0, state IDLE, cur_idx 0. The table contents are not reset.
- States: IDLE, LOAD, SETUP, ACTIVE, GAP.
- IDLE:
  - start with n_layers=0: seq_done pulses next cycle; busy stays 0.
  - start with n_layers>0: go to LOAD, busy=1, cur_idx=0.
  - start while busy is ignored.
- LOAD:
  - Reads words 0..3 of cur_idx over 4 cycles into a shadow register.
  - On the 4th edge, cfg is updated atomically from the shadow.
  - If w0.mode==END: go to IDLE with a seq_done pulse and no strobe.
  - Otherwise go to SETUP. cfg never changes outside this edge.
- SETUP: counts SETUP_CYC edges, then goes to ACTIVE. The strobe selected by mode rises at the transition edge.
- ACTIVE:
  - The strobe is a level, held until done_in is sampled high.
  - On that edge the strobe falls and the state goes to GAP.
  - done_in outside ACTIVE is ignored.
- GAP: counts GAP_CYC edges.
  - If cur_idx+1 < n_layers: cur_idx increments and the state goes to LOAD.
  - Otherwise: go to IDLE, busy=0, seq_done pulses.
  - cur_idx saturates and never wraps.
- Timing: with start sampled at edge t, the strobe is high from edge t+1+4+SETUP_CYC (t+7 at defaults).
- Strobes: at most one of run/wwrite/bwrite is high in any cycle.
- abort:
  - Has priority over every other event, including a simultaneous done_in or start.
  - Next edge: state IDLE, all strobes 0, busy 0, aborted pulses, seq_done does not pulse.
  - cfg holds its last value.
- Asynchronous rst mid-operation: strobes drop immediately.
- n_layers is sampled only at start; later changes are ignored until the next start.

Optional Feature:
- Macro: LAYER_SEQ_LOOP_EN.
- Defined:
  - Adds input port iter (8 bits), sampled at start.
  - After the last descriptor's GAP, the sequence restarts at cur_idx 0 until iter+1 passes are complete; seq_done pulses once, at the end.
  - Adds output pass_cnt (8 bits), reset to 0 and incremented at each restart.
  - iter=0 behaves like a build without the macro.
- Not defined: neither port exists; a single pass is run.

Test Plan:
- Single layer:
  - Write desc0 w0=0x4000_0010 (enbias, run, ds=16), n_layers=1, start at edge t.
  - cfg[31:0]=0x4000_0010 from edge t+5; run high from edge t+7.
  - done_in pulsed at edge t+20: run low after t+20, seq_done pulses 2 cycles later, busy low.
- Three layers with modes wwrite, bwrite, run:
  - Strobes appear in that order, never overlapping, with ≥2 low cycles between them.
  - cur_idx steps 0,1,2.
- END marker: desc1 mode=3, n_layers=4 → only desc0 executes; seq_done pulses after desc1's LOAD with no strobe.
- Simultaneous events:
  - abort and done_in in the same ACTIVE cycle → aborted pulses, no seq_done, no further strobe.
  - start while busy → ignored.
  - tw_en while busy → wr_err pulses and the word is unchanged.
- Boundaries:
  - n_layers=0 start → seq_done pulses the next cycle, no strobe.
  - n_layers=DEPTH → cur_idx reaches 7 and stops.
  - rst asserted mid-ACTIVE → run low before the next edge.
- LAYER_SEQ_LOOP_EN, iter=2, n_layers=2 → six strobes, pass_cnt ends at 2, one seq_done.
